// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared types and defaults for the pipeline flow controller.
// Holds the redirect FSM state encoding and the per-cycle control bundle.
package pipe_flow_ctrl_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } fsm_state_e;

  // en: {ifid, idex, exmem, memwb}; flush: {ifid, idex, exmem}
  typedef struct packed {
    logic       pc_we;
    logic       pc_redirect;
    logic [3:0] en;
    logic [2:0] flush;
  } ctrl_t;

endpackage

// File: rtl/pipe_flow_ctrl_counter.sv
// Wrapping event counter with synchronous active-high clear.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline stall/flush/redirect arbiter; a redirect that arrives during a
// memory stall is parked in PEND and replayed once memory releases.
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcsrc_ex,
  input  logic             jump_ex,
  input  logic [XLEN-1:0]  target_ex,
  input  logic             load_use,
  input  logic             mul_busy,
  input  logic             mem_stall,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  fsm_state_e      r_state;
  fsm_state_e      w_state_nxt;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic            w_redirect_req;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_req = pcsrc_ex | jump_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Only the first redirect seen during a stall is captured; later ones are dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_pc_nxt = r_pend_pc;
    case (r_state)
      RUN: begin
        if (mem_stall && w_redirect_req) begin
          w_state_nxt   = PEND;
          w_pend_pc_nxt = target_ex;
        end
      end
      PEND: begin
        if (!mem_stall) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_ctrl.pc_we       = 1'b1;
    w_ctrl.pc_redirect = 1'b0;
    w_ctrl.en          = 4'b1111;
    w_ctrl.flush       = 3'b000;
    w_redirect_pc      = (r_state == PEND) ? r_pend_pc : target_ex;
    if (reset) begin
      w_ctrl.pc_we  = 1'b0;
      w_ctrl.en     = 4'b0000;
      w_ctrl.flush  = 3'b111;
      w_redirect_pc = '0;
    end else if (mem_stall) begin
      w_ctrl.pc_we = 1'b0;
      w_ctrl.en    = 4'b0000;
    end else if ((r_state == PEND) || w_redirect_req) begin
      w_ctrl.pc_redirect = 1'b1;
      w_ctrl.flush       = 3'b110;
    end else if (mul_busy) begin
      // EX is held, so EX/MEM must receive a bubble while MEM/WB drains.
      w_ctrl.pc_we = 1'b0;
      w_ctrl.en    = 4'b0011;
      w_ctrl.flush = 3'b001;
    end else if (load_use) begin
      w_ctrl.pc_we = 1'b0;
      w_ctrl.en    = 4'b0111;
      w_ctrl.flush = 3'b010;
    end
  end

  assign pc_we       = w_ctrl.pc_we;
  assign pc_redirect = w_ctrl.pc_redirect;
  assign redirect_pc = w_redirect_pc;
  assign ifid_en     = w_ctrl.en[3];
  assign idex_en     = w_ctrl.en[2];
  assign exmem_en    = w_ctrl.en[1];
  assign memwb_en    = w_ctrl.en[0];
  assign ifid_flush  = w_ctrl.flush[2];
  assign idex_flush  = w_ctrl.flush[1];
  assign exmem_flush = w_ctrl.flush[0];

  perf_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_ctrl.pc_redirect),
    .o_cnt   (taken_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (~w_ctrl.pc_we),
    .o_cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed and random checks of pipe_flow_ctrl against a priority-rule model.
module tb_pipe_flow_ctrl;

  localparam int CW = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          pcsrc_ex, jump_ex, load_use, mul_busy, mem_stall;
  logic [XL-1:0] target_ex;
  logic          pc_we, pc_redirect;
  logic [XL-1:0] redirect_pc;
  logic          ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic [CW-1:0] taken_cnt, stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: a waiting redirect target and event tallies
  logic          m_pending = 1'b0;
  logic [31:0]   m_pend_pc = '0;
  int            m_taken   = 0;
  int            m_stall   = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.CNT_W(CW), .XLEN(XL)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcsrc_ex    (pcsrc_ex),
    .jump_ex     (jump_ex),
    .target_ex   (target_ex),
    .load_use    (load_use),
    .mul_busy    (mul_busy),
    .mem_stall   (mem_stall),
    .pc_we       (pc_we),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .taken_cnt   (taken_cnt),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic ms, input logic pc, input logic jp,
                       input logic [31:0] tgt, input logic lu, input logic mb);
    logic       req, e_we, e_rd;
    logic [3:0] e_en;
    logic [2:0] e_fl;
    logic [31:0] e_rpc;
    reset = rst; mem_stall = ms; pcsrc_ex = pc; jump_ex = jp;
    target_ex = tgt; load_use = lu; mul_busy = mb;
    #3;
    req = pc | jp;
    e_rpc = m_pending ? m_pend_pc : tgt;
    e_we = 1'b1; e_rd = 1'b0; e_en = 4'hF; e_fl = 3'b000;
    if (rst) begin
      e_we = 1'b0; e_en = 4'h0; e_fl = 3'b111; e_rpc = '0;
    end else if (ms) begin
      e_we = 1'b0; e_en = 4'h0;
    end else if (m_pending || req) begin
      e_rd = 1'b1; e_fl = 3'b110;
    end else if (mb) begin
      e_we = 1'b0; e_en = 4'b0011; e_fl = 3'b001;
    end else if (lu) begin
      e_we = 1'b0; e_en = 4'b0111; e_fl = 3'b010;
    end
    chk("pc_we", {31'd0, pc_we}, {31'd0, e_we});
    chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_rd});
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("enables", {28'd0, ifid_en, idex_en, exmem_en, memwb_en}, {28'd0, e_en});
    chk("flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, e_fl});
    if (!rst)
      chk("flush_needs_en",
          {29'd0, ifid_flush & ~ifid_en, idex_flush & ~idex_en, exmem_flush & ~exmem_en}, 32'd0);
    chk("taken_cnt", {28'd0, taken_cnt}, m_taken);
    chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
    @(posedge clk);
    if (rst) begin
      m_pending = 1'b0; m_pend_pc = '0; m_taken = 0; m_stall = 0;
    end else begin
      m_taken = (m_taken + (e_rd ? 1 : 0)) % (1 << CW);
      m_stall = (m_stall + (e_we ? 0 : 1)) % (1 << CW);
      if (!m_pending && ms && req) begin
        m_pending = 1'b1; m_pend_pc = tgt;
      end else if (m_pending && !ms) begin
        m_pending = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; pcsrc_ex = 0; jump_ex = 0; target_ex = '0;
    load_use = 0; mul_busy = 0; mem_stall = 0;
    @(posedge clk); #1;
    // reset state
    cycle(1, 0, 0, 0, 32'h0, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    // taken branch, no stalls
    cycle(0, 0, 1, 0, 32'h100, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    // jump during memory stall: oldest target wins
    cycle(0, 1, 0, 1, 32'h200, 0, 0);
    cycle(0, 1, 0, 1, 32'h300, 0, 0);
    cycle(0, 1, 0, 1, 32'h300, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    // redirect beats load-use
    cycle(0, 0, 1, 0, 32'h400, 1, 0);
    // multi-cycle multiply
    repeat (4) cycle(0, 0, 0, 0, 32'h0, 0, 1);
    // redirect beats mul_busy
    cycle(0, 0, 0, 1, 32'h440, 0, 1);
    // reset while pending discards the parked redirect
    cycle(0, 1, 0, 1, 32'h500, 0, 0);
    cycle(1, 1, 0, 0, 32'h0, 0, 0);
    cycle(0, 0, 0, 0, 32'h600, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    // stall counter wrap
    repeat (18) cycle(0, 0, 0, 0, 32'h0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
            ($urandom % 6) == 0, $urandom & 32'hFFFF_FFFC,
            ($urandom % 3) == 0, ($urandom % 4) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
